// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data accesses with starvation guard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic [3:0]  dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve_cnt, starve_nx;
  logic if_el, dm_el, grant_if, grant_dm, ack;
  // arbitration: a requester whose ready is high this cycle is finishing and must not be re-granted
  always_comb begin
    if_el = if_req && !if_ready;
    dm_el = dm_req && !dm_ready;
    grant_dm = state == IDLE && dm_el && !(if_el && starve_cnt == CW'(STARVE_LIMIT));
    grant_if = state == IDLE && if_el && !grant_dm;
    ack = mem_en && mem_ack;
    state_nx = grant_dm ? DM_BUSY : grant_if ? IF_BUSY : ack ? IDLE : state;
    starve_nx = grant_if ? '0 :
                !grant_dm ? starve_cnt :
                !if_req ? '0 :
                starve_cnt == CW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + CW'(1);
  end
  // state and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      starve_cnt <= starve_nx;
    end
  end
  // memory request capture on grant, completion pulse and read data return on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en <= 1'b0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (grant_dm || grant_if) begin
        mem_en <= 1'b1;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        mem_we <= grant_dm ? dm_we : 4'b0000;
        mem_wdata <= grant_dm ? dm_wdata : 32'h0;
      end
      if (ack) begin
        mem_en <= 1'b0;
        if_ready <= state == IF_BUSY;
        dm_ready <= state == DM_BUSY;
        if (state == IF_BUSY) if_rdata <= mem_rdata;
        if (state == DM_BUSY && mem_we == 4'b0000) dm_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  typedef struct {int cyc; logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; bit is_dm;} acc_t;
  typedef struct {int cyc; logic [31:0] data;} cpl_t;
  logic clk = 0, rst = 1;
  logic if_req = 0;
  logic [31:0] if_addr = 0;
  logic [31:0] if_rdata;
  logic if_ready;
  logic dm_req = 0;
  logic [3:0] dm_we = 0;
  logic [31:0] dm_addr = 0, dm_wdata = 0;
  logic [31:0] dm_rdata;
  logic dm_ready;
  logic mem_en;
  logic [3:0] mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic mem_ack = 0;
  int checks = 0, failures = 0, cyc = 0;
  bit gen_new = 0, viol = 0, stray = 0, rd_use_fix = 0, seen = 0, if_done = 0, dm_done = 0;
  int wait_fix = 0, wcnt = 0, n = 0, t_dm = 0, t_if = 0;
  logic [31:0] rd_fix = 0;
  acc_t acc_q[$];
  cpl_t if_q[$], dm_q[$];
  int m_state = 0, m_cnt = 0;
  bit m_if_rdy = 0, m_dm_rdy = 0, m_if_el = 0, m_dm_el = 0;
  logic [3:0] m_we = 0;
  logic [31:0] m_dm_rd = 0;
  logic [31:0] exp_if = 0, exp_dm = 0, h_addr = 0, h_wdata = 0;
  logic [3:0] h_we = 0;
  bit prev_en = 0, r_edge = 0;
  acc_t a;
  cpl_t c;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic mem_drive();
    if (!mem_en) begin
      seen = 0;
      mem_ack = stray && ($urandom % 8 == 0);
      mem_rdata = $urandom;
    end else begin
      if (!seen) begin
        seen = 1;
        wcnt = wait_fix >= 0 ? wait_fix : int'($urandom % 4);
      end
      mem_ack = wcnt == 0;
      mem_rdata = rd_use_fix ? rd_fix : $urandom;
      if (wcnt > 0) wcnt--;
    end
  endtask

  task automatic drive_if();
    if (rst) begin
      if_req = 0;
      if_done = 0;
    end else if (if_ready) if_done = 1;
    else if (if_done) begin
      if_done = 0;
      if_req = gen_new && ($urandom % 2 == 0);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (if_req) begin
      if (viol && $urandom % 24 == 0) if_req = 0;
    end else if (gen_new && $urandom % 3 == 0) begin
      if_req = 1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
  endtask

  task automatic new_dm();
    dm_req = 1;
    dm_addr = $urandom & 32'hFFFF_FFFC;
    dm_we = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    dm_wdata = $urandom;
  endtask

  task automatic drive_dm();
    if (rst) begin
      dm_req = 0;
      dm_done = 0;
    end else if (dm_ready) dm_done = 1;
    else if (dm_done) begin
      dm_done = 0;
      dm_req = 0;
      if (gen_new && $urandom % 2 == 0) new_dm();
    end else if (dm_req) begin
      if (viol && $urandom % 24 == 0) dm_req = 0;
    end else if (gen_new && $urandom % 3 == 0) new_dm();
  endtask

  task automatic tick();
    @(negedge clk);
    mem_drive();
    drive_if();
    drive_dm();
  endtask

  task automatic wait_rdy(input bit is_if);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(is_if ? if_ready : dm_ready) && k < 50);
    chk(is_if ? if_ready : dm_ready, is_if ? "if_ready_timeout" : "dm_ready_timeout", 32'(k), 32'd50);
  endtask

  task automatic dm_txn(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    tick();
    dm_req = 1;
    dm_we = we;
    dm_addr = addr;
    dm_wdata = wdata;
    wait_rdy(1'b0);
  endtask

  // reference model: arbitration rules evaluated on the inputs seen at each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_state = 0;
      m_cnt = 0;
      m_if_rdy = 0;
      m_dm_rdy = 0;
      m_dm_rd = 0;
    end else if (m_state != 0) begin
      m_if_rdy = 0;
      m_dm_rdy = 0;
      if (mem_ack) begin
        if (m_state == 1) begin
          if_q.push_back(cpl_t'{cyc, mem_rdata});
          m_if_rdy = 1;
        end else begin
          if (m_we == 4'h0) m_dm_rd = mem_rdata;
          dm_q.push_back(cpl_t'{cyc, m_dm_rd});
          m_dm_rdy = 1;
        end
        m_state = 0;
      end
    end else begin
      m_if_el = if_req && !m_if_rdy;
      m_dm_el = dm_req && !m_dm_rdy;
      m_if_rdy = 0;
      m_dm_rdy = 0;
      if (m_dm_el && !(m_if_el && m_cnt == LIMIT)) begin
        m_state = 2;
        m_we = dm_we;
        acc_q.push_back(acc_t'{cyc, dm_addr, dm_we, dm_wdata, 1'b1});
        m_cnt = if_req ? (m_cnt < LIMIT ? m_cnt + 1 : LIMIT) : 0;
      end else if (m_if_el) begin
        m_state = 1;
        m_cnt = 0;
        acc_q.push_back(acc_t'{cyc, if_addr, 4'h0, 32'h0, 1'b0});
      end
    end
  end

  // monitor: pops expectations whenever the DUT starts an access or pulses a ready
  initial forever begin
    @(posedge clk);
    r_edge = rst;
    #1;
    if (r_edge) begin
      exp_if = 0;
      exp_dm = 0;
      chk({mem_en, if_ready, dm_ready} === 3'b000, "reset_ctrl", {29'b0, mem_en, if_ready, dm_ready}, 0);
      chk(mem_we === 4'h0, "reset_mem_we", {28'b0, mem_we}, 0);
      chk(mem_addr === 32'h0, "reset_mem_addr", mem_addr, 0);
      chk(mem_wdata === 32'h0, "reset_mem_wdata", mem_wdata, 0);
    end
    if (mem_en && !prev_en) begin
      chk(acc_q.size() != 0, "unexpected_access", mem_addr, 0);
      if (acc_q.size() != 0) begin
        a = acc_q.pop_front();
        chk(a.cyc == cyc, "grant_cycle", 32'(cyc), 32'(a.cyc));
        chk(mem_addr === a.addr, "mem_addr", mem_addr, a.addr);
        chk(mem_we === a.we, "mem_we", {28'b0, mem_we}, {28'b0, a.we});
        if (a.is_dm) chk(mem_wdata === a.wdata, "mem_wdata", mem_wdata, a.wdata);
      end
      h_addr = mem_addr;
      h_we = mem_we;
      h_wdata = mem_wdata;
    end else if (mem_en) begin
      chk(mem_addr === h_addr && mem_we === h_we && mem_wdata === h_wdata, "mem_hold", mem_addr, h_addr);
    end
    if (acc_q.size() != 0) begin
      chk(acc_q[0].cyc >= cyc, "missed_grant", 32'(cyc), 32'(acc_q[0].cyc));
      if (acc_q[0].cyc < cyc) void'(acc_q.pop_front());
    end
    if (if_ready) begin
      chk(if_q.size() != 0, "unexpected_if_ready", if_rdata, exp_if);
      if (if_q.size() != 0) begin
        c = if_q.pop_front();
        chk(c.cyc == cyc, "if_ready_cycle", 32'(cyc), 32'(c.cyc));
        exp_if = c.data;
      end
    end
    if (if_q.size() != 0) begin
      chk(if_q[0].cyc >= cyc, "missed_if_ready", 32'(cyc), 32'(if_q[0].cyc));
      if (if_q[0].cyc < cyc) void'(if_q.pop_front());
    end
    if (dm_ready) begin
      chk(dm_q.size() != 0, "unexpected_dm_ready", dm_rdata, exp_dm);
      if (dm_q.size() != 0) begin
        c = dm_q.pop_front();
        chk(c.cyc == cyc, "dm_ready_cycle", 32'(cyc), 32'(c.cyc));
        exp_dm = c.data;
      end
    end
    if (dm_q.size() != 0) begin
      chk(dm_q[0].cyc >= cyc, "missed_dm_ready", 32'(cyc), 32'(dm_q[0].cyc));
      if (dm_q[0].cyc < cyc) void'(dm_q.pop_front());
    end
    chk(if_rdata === exp_if, "if_rdata", if_rdata, exp_if);
    chk(dm_rdata === exp_dm, "dm_rdata", dm_rdata, exp_dm);
    chk(!(if_ready && dm_ready), "one_ready", {30'b0, if_ready, dm_ready}, 0);
    prev_en = mem_en;
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    wait_fix = 2;
    rd_use_fix = 1;
    rd_fix = 32'hDEADBEEF;
    dm_txn(4'h0, 32'h100, 32'h0);
    chk(dm_rdata === 32'hDEADBEEF, "load_rdata", dm_rdata, 32'hDEADBEEF);
    chk(!if_ready, "load_no_if_ready", {31'b0, if_ready}, 0);
    repeat (3) tick();
    rd_fix = 32'hCAFE0001;
    dm_txn(4'b0011, 32'h2C, 32'h12345678);
    chk(dm_rdata === 32'hDEADBEEF, "store_keeps_rdata", dm_rdata, 32'hDEADBEEF);
    repeat (3) tick();
    wait_fix = 0;
    rd_use_fix = 0;
    tick();
    if_req = 1;
    if_addr = 32'h800;
    dm_req = 1;
    dm_we = 4'h0;
    dm_addr = 32'h900;
    t_dm = 0;
    t_if = 0;
    n = 0;
    while ((t_dm == 0 || t_if == 0) && n < 40) begin
      tick();
      n++;
      if (dm_ready) t_dm = cyc;
      if (if_ready) t_if = cyc;
    end
    chk(t_dm != 0 && t_if == t_dm + 2, "sim_if_after_dm", 32'(t_if), 32'(t_dm + 2));
    repeat (5) tick();
    wait_fix = 1;
    rst = 1;
    tick();
    rst = 0;
    for (int r = 0; r < 5; r++) begin
      tick();
      if_req = 1;
      if_addr = 32'h4000;
      dm_req = 1;
      dm_we = 4'hF;
      dm_addr = 32'h5000 + 32'(r * 4);
      dm_wdata = 32'(r);
      tick();
      chk(mem_en && mem_addr === (r < LIMIT ? 32'h5000 + 32'(r * 4) : 32'h4000), "starve_grant",
          mem_addr, r < LIMIT ? 32'h5000 + 32'(r * 4) : 32'h4000);
      if (r < LIMIT) begin
        if_req = 0;
        wait_rdy(1'b0);
      end else wait_rdy(1'b1);
    end
    repeat (20) tick();
    wait_fix = 6;
    tick();
    if_req = 1;
    if_addr = 32'h7000;
    tick();
    tick();
    chk(mem_en && mem_addr === 32'h7000, "rst_mid_granted", mem_addr, 32'h7000);
    rst = 1;
    tick();
    rst = 0;
    mem_ack = 1;
    mem_rdata = 32'hBAD0BAD0;
    n = 0;
    repeat (10) begin
      tick();
      n += int'(if_ready);
    end
    chk(n == 0, "no_ready_after_rst", 32'(n), 0);
    gen_new = 1;
    viol = 1;
    stray = 1;
    wait_fix = -1;
    repeat (3000) begin
      tick();
      rst = $urandom % 250 == 0;
    end
    tick();
    rst = 0;
    gen_new = 0;
    viol = 0;
    stray = 0;
    repeat (60) tick();
    chk(acc_q.size() == 0 && if_q.size() == 0 && dm_q.size() == 0, "queues_drained",
        32'(acc_q.size() + if_q.size() + dm_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
